bin2bcd_sched: RTL and testbench
================================

BIN2BCD_SCHED -- requirements
Module: bin2bcd_sched

Interface
- REQ-001 Parameter N_REQ, default 4: number of requesters sharing one bin2bcd conversion core (2..8).
- REQ-002 Parameter BIN_W, default 16: binary operand width.
- REQ-003 Parameter BCD_W, default 20: BCD result width, 4 bits per digit.
- REQ-004 Parameter TMO, default 64: core watchdog limit, in cycles.
- REQ-005 clk  input  1  single clock; all logic on posedge clk.
- REQ-006 rst  input  1  reset, synchronous, active-high.
- REQ-007 req_valid  input  N_REQ  per-requester conversion request.
- REQ-008 req_bin  input  N_REQ*BIN_W  per-requester operand; requester i uses slice [i*BIN_W +: BIN_W].
- REQ-009 req_ready  output  N_REQ  one-hot acceptance; a request transfers when req_valid[i] && req_ready[i].
- REQ-010 core_start  output  1  single-cycle start pulse to the core.
- REQ-011 core_bin  output  BIN_W  operand to the core; held stable from core_start until core_done.
- REQ-012 core_done  input  1  single-cycle completion pulse from the core.
- REQ-013 core_bcd  input  BCD_W  core result; valid in the core_done cycle.
- REQ-014 rsp_valid  output  1  response available.
- REQ-015 rsp_id  output  $clog2(N_REQ)  index of the requester that owns the response.
- REQ-016 rsp_bcd  output  BCD_W  converted result; all zeros when rsp_err=1.
- REQ-017 rsp_err  output  1  watchdog expired; no result.
- REQ-018 rsp_ready  input  1  consumer accepts the response when rsp_valid && rsp_ready.

Function
- REQ-019 The block SHALL be an FSM with four states: IDLE, START, WAIT, RESP.
- REQ-020 IDLE: in the same cycle, the block SHALL assert req_ready for exactly one valid requester, chosen round-robin starting at the index after last_grant. It SHALL latch that requester's operand and index, set last_grant, then go to START. With no valid requester it SHALL stay in IDLE.
- REQ-021 req_ready SHALL be all zeros in every state except IDLE. It SHALL never be asserted for a requester whose req_valid is 0.
- REQ-022 START: the block SHALL assert core_start for exactly one cycle, clear the watchdog counter, then go to WAIT.
- REQ-023 WAIT: the block SHALL increment the watchdog each cycle. On core_done it SHALL capture core_bcd, set rsp_err=0 and go to RESP. When the counter reaches TMO-1 without core_done, it SHALL set rsp_bcd=0, rsp_err=1 and go to RESP.
- REQ-024 If core_done and watchdog expiry occur in the same cycle, core_done SHALL win (rsp_err=0).
- REQ-025 core_done outside WAIT SHALL be ignored.
- REQ-026 RESP: the block SHALL hold rsp_valid=1 and keep rsp_id, rsp_bcd and rsp_err stable until rsp_ready. On the handshake cycle it SHALL go to IDLE. rsp_valid SHALL be 0 in all other states.
- REQ-027 Minimum latency: request accept (cycle 0), core_start (cycle 1), core_done at cycle k, rsp_valid from cycle k+1. The next accept occurs no earlier than the cycle after the rsp handshake.
- REQ-028 Fairness: a continuously-valid requester SHALL be granted within N_REQ grants.
- REQ-029 core_bin SHALL equal the latched operand from START through the end of WAIT.

Reset
- REQ-030 On rst=1 at a clock edge, the block SHALL enter IDLE and set:
  - req_ready=0, core_start=0, rsp_valid=0, rsp_err=0, rsp_bcd=0, rsp_id=0, core_bin=0;
  - watchdog=0;
  - last_grant=N_REQ-1, so that requester 0 has first priority.
- REQ-031 Reset during START, WAIT or RESP SHALL abandon the transaction with no response. A later core_done from the abandoned conversion SHALL be ignored.

Verification
- REQ-032 Single request: req_valid=0001, req_bin[0]=16'd1234, core returns 20'h01234 three cycles after core_start -> one core_start pulse with core_bin=1234; rsp_valid with rsp_id=0, rsp_bcd=20'h01234, rsp_err=0.
- REQ-033 Round-robin: all four requesters valid continuously after reset -> grant order 0,1,2,3,0 and rsp_id follows the same order.
- REQ-034 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_bcd stable; req_ready=0 throughout; exactly one response after rsp_ready=1.
- REQ-035 Watchdog, with TMO=64: core_done never asserted -> rsp_valid 64 cycles after the WAIT entry cycle, with rsp_err=1 and rsp_bcd=0. Also core_done coinciding with the expiry cycle -> rsp_err=0.
- REQ-036 Reset mid-WAIT: rst pulse two cycles after core_start, then core_done -> no rsp_valid; the next grant goes to requester 0.
- REQ-037 Boundary operands: req_bin=16'd0 and 16'd65535, core returning 20'h00000 and 20'h65535 -> rsp_bcd matches exactly.

Source files
------------

// File: rtl/bin2bcd_sched.sv
// Round-robin scheduler that shares one bin2bcd conversion core among N_REQ requesters,
// with a watchdog that turns a stalled conversion into an error response.
module bin2bcd_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned BIN_W = 16,
    parameter int unsigned BCD_W = 20,
    parameter int unsigned TMO   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BIN_W-1:0]     req_bin,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       core_start,
    output logic [BIN_W-1:0]           core_bin,
    input  logic                       core_done,
    input  logic [BCD_W-1:0]           core_bcd,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [BCD_W-1:0]           rsp_bcd,
    output logic                       rsp_err,
    input  logic                       rsp_ready
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned WD_W = $clog2(TMO) + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              err_q, err_d;

    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [N_REQ-1:0]  grant_ohot;
    logic [BIN_W-1:0]  grant_bin;

    // Search starts one past the last grant and wraps, so the first hit is the round-robin winner.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        grant_ohot  = '0;
        grant_bin   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((32'(last_grant_q) + off) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_found && grant_idx == ID_W'(i)) begin
                grant_ohot[i] = 1'b1;
                grant_bin     = req_bin[i*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        bin_d        = bin_q;
        wdog_d       = wdog_q;
        bcd_d        = bcd_q;
        err_d        = err_q;
        req_ready    = '0;
        core_start   = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant_ohot;
                if (grant_found) begin
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    bin_d        = grant_bin;
                    state_d      = START;
                end
            end
            START: begin
                core_start = 1'b1;
                wdog_d     = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A completion arriving on the expiry cycle still counts as a good result.
                if (core_done) begin
                    bcd_d   = core_bcd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wdog_q == WD_W'(TMO - 1)) begin
                    bcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            bin_q        <= '0;
            wdog_q       <= '0;
            bcd_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            bin_q        <= bin_d;
            wdog_q       <= wdog_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
        end
    end

    assign core_bin = bin_q;
    assign rsp_id   = id_q;
    assign rsp_bcd  = bcd_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_bin2bcd_sched.sv
// Randomized transaction-level bench for bin2bcd_sched; the bench plays the conversion core
// and predicts grants, results and timing from a round-robin pointer and decimal arithmetic.
module tb_bin2bcd_sched;

    localparam int N    = 4;
    localparam int BW   = 16;
    localparam int DW   = 20;
    localparam int TMOV = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*BW-1:0] req_bin;
    logic [N-1:0]  req_ready;
    logic          core_start;
    logic [BW-1:0] core_bin;
    logic          core_done;
    logic [DW-1:0] core_bcd;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_bcd;
    logic          rsp_err;
    logic          rsp_ready;

    int n_vec = 0;
    int n_err = 0;
    int last  = N - 1;
    logic [BW-1:0] opnd [N];

    bin2bcd_sched #(.N_REQ(N), .BIN_W(BW), .BCD_W(DW), .TMO(TMOV)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_bin(req_bin), .req_ready(req_ready),
        .core_start(core_start), .core_bin(core_bin),
        .core_done(core_done), .core_bcd(core_bcd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] to_bcd(input int unsigned v);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 4; k++) begin
            r[k*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int next_grant(input logic [N-1:0] mask);
        int g;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && mask[(last + k) % N]) g = (last + k) % N;
        end
        return g;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; core_done = 1'b0; core_bcd = '0;
        @(negedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_bcd", 32'(rsp_bcd), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_core_bin", 32'(core_bin), 0);
        rst  = 1'b0;
        last = N - 1;
    endtask

    // d: WAIT cycle (0 = first) on which the core completes; d >= TMO means never.
    // rw: cycles of rsp_ready=0 backpressure before the handshake.
    task automatic do_txn(input logic [N-1:0] mask, input int op, input int d, input int rw);
        int g;
        int exit_c;
        logic [BW-1:0] o;
        logic [DW-1:0] eb;
        logic ee;
        g = next_grant(mask);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            opnd[i] = (op < 0) ? BW'($urandom) : BW'(op);
            req_bin[i*BW +: BW] = opnd[i];
        end
        req_valid = mask; rsp_ready = 1'b0; core_done = 1'b0;
        #1;
        check("grant", 32'(req_ready), 32'(1) << g);
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        o = opnd[g];
        @(negedge clk);
        core_done = 1'b1; core_bcd = DW'($urandom);
        #1;
        check("core_start", 32'(core_start), 1);
        check("core_bin", 32'(core_bin), 32'(o));
        check("ready_busy", 32'(req_ready), 0);
        ee     = !(d >= 0 && d <= TMOV - 1);
        exit_c = ee ? TMOV - 1 : d;
        eb     = ee ? '0 : to_bcd(o);
        for (int c = 0; c <= exit_c; c++) begin
            @(negedge clk);
            core_done = (c == d);
            core_bcd  = (c == d) ? to_bcd(o) : DW'($urandom);
            #1;
            check("wait_quiet", {29'd0, core_start, rsp_valid, |req_ready}, 0);
            check("core_bin_hold", 32'(core_bin), 32'(o));
        end
        for (int r = 0; r <= rw; r++) begin
            @(negedge clk);
            core_done = (r == 0); core_bcd = DW'($urandom);
            rsp_ready = (r == rw);
            #1;
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_id", 32'(rsp_id), 32'(g));
            check("rsp_bcd", 32'(rsp_bcd), 32'(eb));
            check("rsp_err", 32'(rsp_err), 32'(ee));
            check("ready_resp", 32'(req_ready), 0);
        end
        last = g;
    endtask

    task automatic reset_mid(input logic [N-1:0] mask);
        int g;
        g = next_grant(mask);
        @(negedge clk);
        req_valid = mask; rsp_ready = 1'b0; core_done = 1'b0;
        #1;
        check("grant_pre_rst", 32'(req_ready), 32'(1) << g);
        @(negedge clk); #1;
        check("core_start_pre_rst", 32'(core_start), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        rst = 1'b0; core_done = 1'b1; core_bcd = DW'($urandom);
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 0);
        check("post_rst_core_bin", 32'(core_bin), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            core_done = c[0]; core_bcd = DW'($urandom);
            #1;
            check("abandoned_quiet", {30'd0, rsp_valid, core_start}, 0);
        end
        core_done = 1'b0;
        last = N - 1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_bin = '0; rsp_ready = 1'b0;
        core_done = 1'b0; core_bcd = '0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("idle_quiet", {30'd0, |req_ready, core_start}, 0);
        end
        do_txn(4'b0001, 1234, 2, 0);
        do_reset();
        for (int t = 0; t < 5; t++) do_txn(4'hF, -1, $urandom_range(0, 4), 0);
        do_txn(4'($urandom_range(1, 15)), -1, 3, 10);
        do_txn(4'hF, -1, 1000, 0);
        do_txn(4'hF, -1, TMOV - 1, 0);
        do_txn(4'hF, -1, TMOV - 2, 1);
        do_txn(4'b0110, -1, 0, 0);
        reset_mid(4'b1110);
        do_txn(4'hF, -1, 1, 0);
        do_txn(4'b0100, 0, 1, 0);
        do_txn(4'b1000, 65535, 0, 2);
        for (int t = 0; t < 25; t++) begin
            do_txn(4'($urandom_range(1, 15)), -1, $urandom_range(0, 9), $urandom_range(0, 3));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
